dir_rom_seq: RTL and testbench

DIR_ROM_SEQ -- requirements
Module: dir_rom_seq

---
 rtl/dir_rom_seq_pkg.sv | 13 +
 rtl/dir_rom_seq_if.sv | 18 +
 rtl/dir_rom_seq_ctr.sv | 34 +++
 rtl/dir_rom_seq.sv | 111 +++++++++++
 tb/tb_dir_rom_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dir_rom_seq_pkg.sv
// Shared definitions for the direction-ROM sweep sequencer: default widths and FSM encoding.
package dir_rom_seq_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/dir_rom_seq_if.sv
// Valid/ready beat stream carrying one ROM direction sample per transfer.
interface dir_rom_seq_if
  import dir_rom_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] dir;
  logic              last;

  modport master (output valid, idx, dir, last, input ready);
  modport slave  (input valid, idx, dir, last, output ready);

endinterface

// File: rtl/dir_rom_seq_ctr.sv
// Wrapping sweep address counter; holds the latched end address and flags the terminal beat.
module dir_rom_seq_ctr
  import dir_rom_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_first,
  input  logic [ADDR_W-1:0] load_last,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              at_last
);

  logic [ADDR_W-1:0] last_q;

  // Natural overflow gives the modulo-2^ADDR_W wrap, so last<first sweeps through zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      last_q <= '0;
    end else if (load) begin
      cnt    <= load_first;
      last_q <= load_last;
    end else if (inc) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  assign at_last = (cnt == last_q);

endmodule

// File: rtl/dir_rom_seq.sv
// Sweeps a combinational direction ROM from a first to a last address and streams the
// samples out through a registered valid/ready stage.
module dir_rom_seq
  import dir_rom_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   cfg_first,
  input  logic [ADDR_W-1:0]   cfg_last,
  output logic [ADDR_W-1:0]   rom_a,
  input  logic [DATA_W-1:0]   rom_spo,
  dir_rom_seq_if.master       out,
  output logic                busy,
  output logic                done
);

  seq_state_e        state, state_nx;
  logic              fire, load, out_load, out_clr, done_set;
  logic [ADDR_W-1:0] cnt, rom_a_q;
  logic              at_last;

  dir_rom_seq_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_first (cfg_first),
    .load_last  (cfg_last),
    .inc        (out_load),
    .cnt        (cnt),
    .at_last    (at_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Abort takes priority over any handshake, so an aborted sweep never signals done.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    out_load = 1'b0;
    out_clr  = 1'b0;
    done_set = 1'b0;
    fire     = !out.valid || out.ready;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          load     = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          out_clr  = 1'b1;
          state_nx = ST_IDLE;
        end else if (fire) begin
          out_load = 1'b1;
          if (at_last) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          out_clr  = 1'b1;
          state_nx = ST_IDLE;
        end else if (out.valid && out.ready && out.last) begin
          out_clr  = 1'b1;
          done_set = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.valid <= 1'b0;
      out.idx   <= '0;
      out.dir   <= '0;
      out.last  <= 1'b0;
    end else if (out_clr) begin
      out.valid <= 1'b0;
    end else if (out_load) begin
      out.valid <= 1'b1;
      out.idx   <= cnt;
      out.dir   <= rom_spo;
      out.last  <= at_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      rom_a_q <= '0;
    end else begin
      done    <= done_set;
      rom_a_q <= rom_a;
    end
  end

  // Outside RUN the ROM address is frozen so the external ROM sees no spurious toggles.
  assign rom_a = (state == ST_RUN) ? cnt : rom_a_q;
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_dir_rom_seq.sv
// Directed bench for dir_rom_seq: sweeps, wrap, single beat, backpressure, abort/reset, busy start.
module tb_dir_rom_seq;
  import dir_rom_seq_pkg::*;

  localparam int AW   = ADDR_W_DEF;
  localparam int DW   = DATA_W_DEF;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [AW-1:0] cfg_first, cfg_last, rom_a;
  logic [DW-1:0] rom_spo;
  logic          busy, done;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int beat_idx[$];
  int beat_dir[$];
  int beat_last[$];
  int done_count, done_cyc, first_beat_cyc, last_beat_cyc;

  bit            stalled = 1'b0;
  logic [AW-1:0] prev_idx;
  logic [DW-1:0] prev_dir;
  logic          prev_last;

  dir_rom_seq_if #(.ADDR_W(AW), .DATA_W(DW)) out_if ();

  dir_rom_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_first (cfg_first),
    .cfg_last  (cfg_last),
    .rom_a     (rom_a),
    .rom_spo   (rom_spo),
    .out       (out_if),
    .busy      (busy),
    .done      (done)
  );

  // Direction ROM model: (a[3:0] + 24) mod 32.
  assign rom_spo = {1'b0, rom_a[3:0]} + 5'd24;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual,
               expected, expected);
    end
  endtask

  // Scoreboard side: records every transfer and checks the stream holds still while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_if.valid) begin
        checkOutput("stall_idx", int'(out_if.idx), int'(prev_idx));
        checkOutput("stall_dir", int'(out_if.dir), int'(prev_dir));
        checkOutput("stall_last", int'(out_if.last), int'(prev_last));
      end
      if (out_if.valid && out_if.ready) begin
        if (beat_idx.size() == 0) first_beat_cyc = cyc;
        beat_idx.push_back(int'(out_if.idx));
        beat_dir.push_back(int'(out_if.dir));
        beat_last.push_back(int'(out_if.last));
        if (out_if.last) last_beat_cyc = cyc;
      end
      if (done) begin
        if (done_count == 0) done_cyc = cyc;
        done_count++;
      end
      stalled   = out_if.valid && !out_if.ready;
      prev_idx  = out_if.idx;
      prev_dir  = out_if.dir;
      prev_last = out_if.last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearScoreboard();
    beat_idx.delete();
    beat_dir.delete();
    beat_last.delete();
    done_count     = 0;
    done_cyc       = -1;
    first_beat_cyc = -1;
    last_beat_cyc  = -1;
  endtask

  task automatic applyStimulus(input int first, input int last);
    clearScoreboard();
    cfg_first = AW'(first);
    cfg_last  = AW'(last);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // ready_mode 0 holds out_ready high, 1 drives it pseudo-randomly; inject_at pulses a stray start.
  task automatic waitForDone(input int ready_mode, input int budget, input int inject_at);
    int n;
    n = 0;
    while (done_count == 0 && n < budget) begin
      out_if.ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start = (n == inject_at);
      if (n == inject_at) begin
        cfg_first = AW'(100);
        cfg_last  = AW'(100);
      end
      tick();
      n++;
    end
    start        = 1'b0;
    out_if.ready = 1'b1;
    tick();
    tick();
    checkOutput("done_once", done_count, 1);
    checkOutput("idle_after_sweep", int'(busy), 0);
  endtask

  task automatic checkBeats(input int first, input int last);
    int n, idx, dir;
    n = ((last - first) & MASK) + 1;
    checkOutput("beat_count", beat_idx.size(), n);
    for (int i = 0; i < n && i < beat_idx.size(); i++) begin
      idx = (first + i) & MASK;
      dir = ((idx & 15) + 24) & 31;
      checkOutput("beat_idx", beat_idx[i], idx);
      checkOutput("beat_dir", beat_dir[i], dir);
      checkOutput("beat_last", beat_last[i], int'(i == n - 1));
    end
  endtask

  task automatic interruptAt5th(input int use_rst);
    int n;
    applyStimulus(0, 31);
    out_if.ready = 1'b1;
    n = 0;
    while (!(out_if.valid && beat_idx.size() == 4) && n < 50) begin
      tick();
      n++;
    end
    checkOutput("reach_5th", int'(n < 50), 1);
    checkOutput("fifth_idx", int'(out_if.idx), 4);
    if (use_rst != 0) rst = 1'b1;
    else              abort = 1'b1;
    tick();
    rst   = 1'b0;
    abort = 1'b0;
    checkOutput("intr_valid", int'(out_if.valid), 0);
    checkOutput("intr_busy", int'(busy), 0);
    if (use_rst != 0) begin
      checkOutput("rst_mid_idx", int'(out_if.idx), 0);
      checkOutput("rst_mid_rom_a", int'(rom_a), 0);
    end
    tick();
    tick();
    tick();
    checkOutput("intr_no_done", done_count, 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    cfg_first    = '0;
    cfg_last     = '0;
    out_if.ready = 1'b1;
    clearScoreboard();
    tick();
    tick();
    checkOutput("rst_valid", int'(out_if.valid), 0);
    checkOutput("rst_last", int'(out_if.last), 0);
    checkOutput("rst_idx", int'(out_if.idx), 0);
    checkOutput("rst_dir", int'(out_if.dir), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_rom_a", int'(rom_a), 0);
    rst = 1'b0;
    tick();

    cfg_first = AW'(3);
    cfg_last  = AW'(4);
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("idle_abort_busy", int'(busy), 0);
    tick();
    checkOutput("idle_abort_valid", int'(out_if.valid), 0);

    applyStimulus(0, 15);
    checkOutput("lat_busy", int'(busy), 1);
    checkOutput("lat_valid_c1", int'(out_if.valid), 0);
    checkOutput("lat_rom_a", int'(rom_a), 0);
    tick();
    checkOutput("lat_valid_c2", int'(out_if.valid), 1);
    checkOutput("lat_idx", int'(out_if.idx), 0);
    checkOutput("lat_dir", int'(out_if.dir), 'h18);
    waitForDone(0, 100, -1);
    checkBeats(0, 15);
    checkOutput("done_gap", done_cyc - last_beat_cyc, 1);
    checkOutput("throughput", last_beat_cyc - first_beat_cyc, 15);

    applyStimulus(250, 3);
    waitForDone(0, 100, -1);
    checkBeats(250, 3);

    applyStimulus(9, 9);
    waitForDone(0, 50, -1);
    checkBeats(9, 9);

    applyStimulus(0, 31);
    waitForDone(1, 400, -1);
    checkBeats(0, 31);

    applyStimulus(0, 15);
    waitForDone(1, 300, 6);
    checkBeats(0, 15);

    interruptAt5th(0);
    applyStimulus(250, 3);
    waitForDone(0, 100, -1);
    checkBeats(250, 3);

    interruptAt5th(1);
    applyStimulus(0, 15);
    waitForDone(0, 100, -1);
    checkBeats(0, 15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
